// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the timing FSM state type.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic {
        ST_WAIT_LOCK = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level signals.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: lock-gated h/v counters with registered,
// mutually aligned sync, blanking and position outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
    parameter int unsigned H_FP            = VGA_H_FP,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BP            = VGA_H_BP,
    parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
    parameter int unsigned V_FP            = VGA_V_FP,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BP            = VGA_V_BP,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             video_active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic             locked_s;
    state_t           state_q;
    logic             advance;
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic             running_q, running_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: if (locked_s)  state_q <= ST_RUN;
                ST_RUN:       if (!locked_s) state_q <= ST_WAIT_LOCK;
                default:                     state_q <= ST_WAIT_LOCK;
            endcase
        end
    end

    // A lost lock blanks the very cycle the FSM leaves RUN.
    assign advance = (state_q == ST_RUN) && locked_s;
    assign h_wrap  = (h_cnt_q == H_LAST);
    assign v_wrap  = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (advance) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            v_cnt_d = v_cnt_q;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        hsync_d   = SYNC_IDLE;
        vsync_d   = SYNC_IDLE;
        video_d   = 1'b0;
        x_d       = '0;
        y_d       = '0;
        line_d    = 1'b0;
        frame_d   = 1'b0;
        running_d = 1'b0;
        if (advance) begin
            hsync_d   = SYNC_IDLE ^ ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
            vsync_d   = SYNC_IDLE ^ ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
            video_d   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
            x_d       = h_cnt_q;
            y_d       = v_cnt_q;
            line_d    = (h_cnt_q == '0);
            frame_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
            running_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q   <= SYNC_IDLE;
            vsync_q   <= SYNC_IDLE;
            video_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            video_q   <= video_d;
            x_q       <= x_d;
            y_q       <= y_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
            running_q <= running_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_active = video_q;
    assign x            = x_q;
    assign y            = y_q;
    assign line_start   = line_q;
    assign frame_start  = frame_q;
    assign running      = running_q;

endmodule
